// File: rtl/ip_pkg.sv
// Shared definitions for the instruction-pointer checkpoint unit:
// default geometry and the LIFO operation code passed from the decoder
// in the top level to the checkpoint stack.
package ip_pkg;

    localparam int IP_WIDTH_DEF   = 16;
    localparam int INC_W_DEF      = 4;
    localparam int CKPT_DEPTH_DEF = 4;
    localparam int LEN_W_DEF      = 4;

    // One operation per cycle after arbitration of push/pop/restore.
    // CK_REPLACE overwrites the top entry (push and pop together).
    typedef enum logic [2:0] {
        CK_NONE,
        CK_PUSH,
        CK_POP,
        CK_REPLACE,
        CK_RESTORE
    } ckpt_op_t;

endpackage

// File: rtl/ip_ckpt_stack.sv
// Checkpoint LIFO: DEPTH x WIDTH register array plus an occupancy counter.
// Rejected operations (push when full, pop/restore when empty) leave the
// stack untouched and raise a one-cycle err pulse.
module ip_ckpt_stack
    import ip_pkg::*;
#(
    parameter int WIDTH = IP_WIDTH_DEF,
    parameter int DEPTH = CKPT_DEPTH_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  ckpt_op_t                     op,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             top,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic                         err
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_addr;
    logic             do_write;
    logic             do_inc;
    logic             do_dec;

    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);
    assign top_idx = AW'(depth - DW'(1));
    assign top     = empty ? '0 : mem[top_idx];

    // Decode the requested operation into write/count controls and the error pulse.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        do_write = 1'b0;
        do_inc   = 1'b0;
        do_dec   = 1'b0;
        err      = 1'b0;
        wr_addr  = AW'(depth);
        case (op)
            CK_PUSH: begin
                if (full) begin
                    err = 1'b1;
                end else begin
                    do_write = 1'b1;
                    do_inc   = 1'b1;
                end
            end
            CK_REPLACE: begin
                // Replacing on an empty stack degenerates into a push.
                do_write = 1'b1;
                if (empty) begin
                    do_inc = 1'b1;
                end else begin
                    wr_addr = top_idx;
                end
            end
            CK_POP, CK_RESTORE: begin
                if (empty) begin
                    err = 1'b1;
                end else begin
                    do_dec = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Occupancy counter; reset discards all checkpoints.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            depth <= '0;
        end else if (do_inc) begin
            depth <= depth + DW'(1);
        end else if (do_dec) begin
            depth <= depth - DW'(1);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; entries at or above depth are never observed.
        if (do_write) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/ip_ckpt_unit.sv
// Instruction-pointer register with single-instruction rollback, a LIFO
// of saved instruction-start checkpoints and a running instruction length.
module ip_ckpt_unit
    import ip_pkg::*;
#(
    parameter int WIDTH = IP_WIDTH_DEF,
    parameter int INC_W = INC_W_DEF,
    parameter int DEPTH = CKPT_DEPTH_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start_instruction,
    input  logic                         next_instruction,
    input  logic                         rollback,
    input  logic [INC_W-1:0]             inc,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_val,
    input  logic                         ckpt_push,
    input  logic                         ckpt_pop,
    input  logic                         ckpt_restore,
    input  logic                         err_clr,
    output logic [WIDTH-1:0]             val,
    output logic [WIDTH-1:0]             start_val,
    output logic [LEN_W-1:0]             instr_len,
    output logic [$clog2(DEPTH+1)-1:0]   ckpt_depth,
    output logic                         ckpt_full,
    output logic                         ckpt_empty,
    output logic                         ckpt_err
);

    ckpt_op_t         op;
    logic [WIDTH-1:0] stk_top;
    logic             stk_err;
    logic             restore_ok;
    logic [WIDTH-1:0] val_d;
    logic [WIDTH-1:0] start_d;

    // A restore only counts when there is an entry to return to.
    assign restore_ok = ckpt_restore && !ckpt_empty;
    assign instr_len  = LEN_W'(val - start_val);

    // Collapse the three LIFO strobes into one operation; restore masks push/pop.
    always_comb begin
        op = CK_NONE;
        if (ckpt_restore) begin
            op = CK_RESTORE;
        end else if (ckpt_push && ckpt_pop) begin
            op = CK_REPLACE;
        end else if (ckpt_push) begin
            op = CK_PUSH;
        end else if (ckpt_pop) begin
            op = CK_POP;
        end
    end

    ip_ckpt_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .reset_n (reset_n),
        .op      (op),
        .wr_data (start_val),
        .top     (stk_top),
        .depth   (ckpt_depth),
        .full    (ckpt_full),
        .empty   (ckpt_empty),
        .err     (stk_err)
    );

    // Next current-IP: direct load, then restore, then rollback, then advance.
    always_comb begin
        val_d = val;
        if (wr_en) begin
            val_d = wr_val;
        end else if (restore_ok) begin
            val_d = stk_top;
        end else if (rollback) begin
            val_d = start_val;
        end else if (start_instruction) begin
            val_d = val + WIDTH'(inc);
        end
    end

    // Next instruction-start: restore wins, otherwise latch the boundary.
    always_comb begin
        start_d = start_val;
        if (restore_ok) begin
            start_d = stk_top;
        end else if (next_instruction) begin
            start_d = wr_en ? wr_val : val;
        end
    end

    // IP registers and sticky error; a rejected op beats a clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            val       <= '0;
            start_val <= '0;
            ckpt_err  <= 1'b0;
        end else begin
            val       <= val_d;
            start_val <= start_d;
            if (stk_err) begin
                ckpt_err <= 1'b1;
            end else if (err_clr) begin
                ckpt_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ip_ckpt_unit.sv
// Self-checking bench for ip_ckpt_unit: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_ip_ckpt_unit;

    localparam int WIDTH = 16;
    localparam int INC_W = 4;
    localparam int DEPTH = 4;
    localparam int LEN_W = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start_instruction;
    logic             next_instruction;
    logic             rollback;
    logic [INC_W-1:0] inc;
    logic             wr_en;
    logic [WIDTH-1:0] wr_val;
    logic             ckpt_push;
    logic             ckpt_pop;
    logic             ckpt_restore;
    logic             err_clr;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] start_val;
    logic [LEN_W-1:0] instr_len;
    logic [DW-1:0]    ckpt_depth;
    logic             ckpt_full;
    logic             ckpt_empty;
    logic             ckpt_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] m_val;
    logic [WIDTH-1:0] m_start;
    logic [WIDTH-1:0] m_q[$];
    logic             m_err;

    ip_ckpt_unit #(
        .WIDTH (WIDTH),
        .INC_W (INC_W),
        .DEPTH (DEPTH),
        .LEN_W (LEN_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start_instruction (start_instruction),
        .next_instruction  (next_instruction),
        .rollback          (rollback),
        .inc               (inc),
        .wr_en             (wr_en),
        .wr_val            (wr_val),
        .ckpt_push         (ckpt_push),
        .ckpt_pop          (ckpt_pop),
        .ckpt_restore      (ckpt_restore),
        .err_clr           (err_clr),
        .val               (val),
        .start_val         (start_val),
        .instr_len         (instr_len),
        .ckpt_depth        (ckpt_depth),
        .ckpt_full         (ckpt_full),
        .ckpt_empty        (ckpt_empty),
        .ckpt_err          (ckpt_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_idle();
        reset_n           = 1'b1;
        start_instruction = 1'b0;
        next_instruction  = 1'b0;
        rollback          = 1'b0;
        inc               = '0;
        wr_en             = 1'b0;
        wr_val            = '0;
        ckpt_push         = 1'b0;
        ckpt_pop          = 1'b0;
        ckpt_restore      = 1'b0;
        err_clr           = 1'b0;
    endtask

    // Behavioural model of one clock edge, from the pre-edge state and inputs.
    task automatic model_step();
        logic [WIDTH-1:0] top;
        logic             restored;
        logic             rejected;
        logic [WIDTH-1:0] nv;
        logic [WIDTH-1:0] ns;
        if (!reset_n) begin
            m_val   = '0;
            m_start = '0;
            m_err   = 1'b0;
            m_q.delete();
            return;
        end
        top      = '0;
        restored = 1'b0;
        rejected = 1'b0;
        if (ckpt_restore) begin
            if (m_q.size() == 0) rejected = 1'b1;
            else begin
                top      = m_q.pop_back();
                restored = 1'b1;
            end
        end else if (ckpt_push && ckpt_pop) begin
            if (m_q.size() == 0) m_q.push_back(m_start);
            else m_q[m_q.size()-1] = m_start;
        end else if (ckpt_push) begin
            if (m_q.size() == DEPTH) rejected = 1'b1;
            else m_q.push_back(m_start);
        end else if (ckpt_pop) begin
            if (m_q.size() == 0) rejected = 1'b1;
            else void'(m_q.pop_back());
        end

        if (wr_en)                  nv = wr_val;
        else if (restored)          nv = top;
        else if (rollback)          nv = m_start;
        else if (start_instruction) nv = WIDTH'((int'(m_val) + int'(inc)) % (1 << WIDTH));
        else                        nv = m_val;

        if (restored)              ns = top;
        else if (next_instruction) ns = wr_en ? wr_val : m_val;
        else                       ns = m_start;

        if (rejected)     m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_val   = nv;
        m_start = ns;
    endtask

    task automatic compare_all();
        int len;
        len = (int'(m_val) - int'(m_start) + (1 << WIDTH)) % (1 << LEN_W);
        check("val",        32'(val),        32'(m_val));
        check("start_val",  32'(start_val),  32'(m_start));
        check("instr_len",  32'(instr_len),  32'(len));
        check("ckpt_depth", 32'(ckpt_depth), 32'(m_q.size()));
        check("ckpt_full",  32'(ckpt_full),  32'(m_q.size() == DEPTH));
        check("ckpt_empty", 32'(ckpt_empty), 32'(m_q.size() == 0));
        check("ckpt_err",   32'(ckpt_err),   32'(m_err));
    endtask

    // Apply current inputs for one edge, then compare 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        m_val   = '0;
        m_start = '0;
        m_err   = 1'b0;
        set_idle();

        // Reset and advance
        reset_n = 1'b0;
        cycle();
        check("rst_val", 32'(val), 32'h0);
        check("rst_depth", 32'(ckpt_depth), 32'h0);
        set_idle(); wr_en = 1'b1; wr_val = 16'h0100; cycle();
        set_idle(); start_instruction = 1'b1; inc = 4'd3; cycle(); cycle();
        check("adv_val", 32'(val), 32'h0106);
        check("adv_start", 32'(start_val), 32'h0000);
        check("adv_len", 32'(instr_len), 32'h6);
        set_idle(); next_instruction = 1'b1; cycle();
        check("ni_start", 32'(start_val), 32'h0106);
        check("ni_len", 32'(instr_len), 32'h0);

        // Wrap and rollback
        set_idle(); wr_en = 1'b1; wr_val = 16'hFFFE; next_instruction = 1'b1; cycle();
        set_idle(); start_instruction = 1'b1; inc = 4'd3; cycle();
        check("wrap_val", 32'(val), 32'h0001);
        set_idle(); rollback = 1'b1; cycle();
        check("rb_val", 32'(val), 32'hFFFE);

        // Nested restore
        set_idle(); wr_en = 1'b1; wr_val = 16'h0010; next_instruction = 1'b1; cycle();
        set_idle(); ckpt_push = 1'b1; cycle();
        set_idle(); wr_en = 1'b1; wr_val = 16'h0020; next_instruction = 1'b1; cycle();
        set_idle(); ckpt_push = 1'b1; cycle();
        set_idle(); start_instruction = 1'b1; inc = 4'd15; cycle();
        set_idle(); start_instruction = 1'b1; inc = 4'd4; cycle();
        check("nest_val", 32'(val), 32'h0033);
        check("nest_depth", 32'(ckpt_depth), 32'h2);
        set_idle(); ckpt_restore = 1'b1; cycle();
        check("rs1_val", 32'(val), 32'h0020);
        check("rs1_start", 32'(start_val), 32'h0020);
        check("rs1_depth", 32'(ckpt_depth), 32'h1);
        cycle();
        check("rs2_val", 32'(val), 32'h0010);
        check("rs2_empty", 32'(ckpt_empty), 32'h1);

        // Overflow / underflow
        for (int k = 0; k < 5; k++) begin
            set_idle(); ckpt_push = 1'b1; wr_en = 1'b1; next_instruction = 1'b1;
            wr_val = WIDTH'((k + 1) * 16'h0100);
            cycle();
        end
        check("ovf_depth", 32'(ckpt_depth), 32'h4);
        check("ovf_full", 32'(ckpt_full), 32'h1);
        check("ovf_err", 32'(ckpt_err), 32'h1);
        set_idle(); err_clr = 1'b1; cycle();
        check("clr_err", 32'(ckpt_err), 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_idle(); ckpt_restore = 1'b1; cycle();
        end
        check("drain_val", 32'(val), 32'h0010);
        set_idle(); ckpt_pop = 1'b1; cycle();
        check("unf_err", 32'(ckpt_err), 32'h1);
        check("unf_depth", 32'(ckpt_depth), 32'h0);

        // Simultaneous operations
        set_idle(); wr_en = 1'b1; wr_val = 16'h0030; next_instruction = 1'b1; cycle();
        set_idle(); ckpt_push = 1'b1; cycle();
        set_idle(); wr_en = 1'b1; wr_val = 16'h0035; next_instruction = 1'b1; cycle();
        set_idle(); ckpt_push = 1'b1; cycle();
        set_idle(); wr_en = 1'b1; wr_val = 16'h0040; next_instruction = 1'b1; cycle();
        set_idle(); ckpt_push = 1'b1; ckpt_pop = 1'b1; cycle();
        check("repl_depth", 32'(ckpt_depth), 32'h2);
        set_idle(); wr_en = 1'b1; wr_val = 16'h0200; ckpt_restore = 1'b1; cycle();
        check("wrrs_val", 32'(val), 32'h0200);
        check("wrrs_start", 32'(start_val), 32'h0040);
        check("wrrs_depth", 32'(ckpt_depth), 32'h1);
        set_idle(); rollback = 1'b1; start_instruction = 1'b1; inc = 4'd5; cycle();
        check("rb_wins", 32'(val), 32'h0040);

        // Reset mid-sequence
        set_idle(); ckpt_push = 1'b1; cycle(); cycle();
        check("pre_depth", 32'(ckpt_depth), 32'h3);
        check("pre_err", 32'(ckpt_err), 32'h1);
        set_idle(); reset_n = 1'b0; ckpt_push = 1'b1; cycle();
        check("mid_depth", 32'(ckpt_depth), 32'h0);
        check("mid_err", 32'(ckpt_err), 32'h0);
        check("mid_val", 32'(val), 32'h0);
        check("mid_start", 32'(start_val), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            reset_n           = ($urandom_range(63) != 0);
            start_instruction = ($urandom_range(1) == 0);
            next_instruction  = ($urandom_range(2) == 0);
            rollback          = ($urandom_range(7) == 0);
            inc               = INC_W'($urandom_range(15));
            wr_en             = ($urandom_range(7) == 0);
            wr_val            = ($urandom_range(3) == 0) ? WIDTH'(16'hFFF0 + $urandom_range(15))
                                                         : WIDTH'($urandom);
            ckpt_push         = ($urandom_range(2) == 0);
            ckpt_pop          = ($urandom_range(3) == 0);
            ckpt_restore      = ($urandom_range(5) == 0);
            err_clr           = ($urandom_range(7) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ip_ckpt_unit.md
Name: ip_ckpt_unit

Overview:
- Parametrised successor to the CPU instruction-pointer register, for the microcode-driven front end.
- Tracks the current IP and the start address of the current instruction. Supports single-instruction rollback, as the existing IP block does.
- Adds a LIFO of saved instruction-start checkpoints. Nested restartable sequences (REP string ops, fault/interrupt restart) can return to an older instruction boundary.
- Also reports the running length of the current instruction.

Parameters:
- WIDTH, 16, IP width in bits; all IP arithmetic is modulo 2^WIDTH.
- INC_W, 4, width of the per-fetch increment.
- DEPTH, 4, checkpoint LIFO entries (>=1).
- LEN_W, 4, width of the instr_len output.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start_instruction  in  1  advance cur_val by inc
- next_instruction  in  1  latch new instruction boundary
- rollback  in  1  cur_val <= start_val
- inc  in  INC_W  bytes consumed (zero-extended)
- wr_en  in  1  direct IP load (jump/call/ret)
- wr_val  in  WIDTH  value for wr_en
- ckpt_push  in  1  push start_val onto LIFO
- ckpt_pop  in  1  discard top entry
- ckpt_restore  in  1  cur_val, start_val <= top; pop
- err_clr  in  1  clear ckpt_err
- val  out  WIDTH  current IP
- start_val  out  WIDTH  start address of current instruction
- instr_len  out  LEN_W  (val - start_val) mod 2^WIDTH, low LEN_W bits
- ckpt_depth  out  $clog2(DEPTH+1)  occupied entries
- ckpt_full  out  1  ckpt_depth == DEPTH
- ckpt_empty  out  1  ckpt_depth == 0
- ckpt_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (reset_n low at a clk edge) zeroes val, start_val, ckpt_depth and ckpt_err. LIFO contents become don't-care. Reset overrides every other input in that cycle. Reset mid-sequence discards all checkpoints.
- All state updates happen on the clk rising edge. Outputs are registered values, except instr_len, ckpt_full and ckpt_empty, which decode combinationally from registers.
- cur_val priority per cycle:
  - wr_en: cur_val <= wr_val.
  - else valid ckpt_restore: cur_val <= top.
  - else rollback: cur_val <= start_val.
  - else start_instruction: cur_val <= cur_val + zext(inc), wrapping modulo 2^WIDTH (0xFFFE + 3 -> 0x0001).
  - else hold.
- start_val:
  - valid ckpt_restore: start_val <= top.
  - else next_instruction: start_val <= wr_en ? wr_val : cur_val (pre-edge value).
  - else hold.
- LIFO operations (the "op" is the combination of push, pop and restore asserted in a cycle):
  - Push stores the pre-edge start_val. When full it is ignored and sets ckpt_err.
  - Pop when empty is ignored and sets ckpt_err.
  - Restore when empty is ignored and sets ckpt_err; it is then invalid, so the cur_val/start_val arbitration falls through to the lower priorities.
  - Push + pop together with depth>0: top is replaced by start_val, depth unchanged. With depth==0: behaves as push.
  - Restore with push or pop in the same cycle: restore only; push and pop are ignored, no error.
  - Restore with wr_en: the LIFO still pops and start_val <= top, but cur_val <= wr_val.
- ckpt_err: set by any rejected op. Cleared by err_clr only when no rejected op occurs that cycle; a set wins over a clear.
- No handshakes: every op completes in one cycle, and val reflects it the next cycle.

Decomposition:
- Package ip_pkg:
  - localparams for default WIDTH/DEPTH.
  - enum ckpt_op_t {CK_NONE, CK_PUSH, CK_POP, CK_REPLACE, CK_RESTORE}, used by the decoder and the sub-module.
- Sub-module ip_ckpt_stack:
  - Parametrised LIFO (DEPTH x WIDTH register array plus depth counter).
  - Inputs: ckpt_op_t and write data.
  - Outputs: top, depth, full, empty, err pulse.
- The top level holds cur_val/start_val, op decode, priority muxing and the sticky error.

Test Plan:
- Reset and advance: reset_n=0, then wr_en with wr_val=0x0100; start_instruction with inc=3 twice -> val=0x0106, start_val=0x0000, instr_len=6; next_instruction -> start_val=0x0106, instr_len=0.
- Wrap: wr_val=0xFFFE, then start_instruction with inc=3 -> val=0x0001; rollback with start_val=0xFFFE -> val=0xFFFE.
- Nested restore: checkpoints pushed at start_val 0x0010 and then 0x0020 (depth=2), ip advanced to 0x0033; ckpt_restore -> val=start_val=0x0020, depth=1; again -> 0x0010, depth=0, ckpt_empty=1.
- Overflow/underflow (DEPTH=4): five pushes -> depth=4, ckpt_full=1, ckpt_err=1, contents unchanged; err_clr -> err=0; pop on empty -> err=1, depth=0.
- Simultaneous: push+pop at depth 2 with start_val=0x0040 -> top=0x0040, depth 2; wr_en=0x0200 + ckpt_restore -> val=0x0200, start_val=old top, depth 1; rollback + start_instruction -> rollback wins.
- Reset mid-sequence: depth=3 and err=1, reset_n=0 for one cycle during ckpt_push -> depth=0, err=0, val=0, start_val=0.
